cmd_framer: RTL and testbench

CMD_FRAMER -- requirements
Module: cmd_framer

---
 rtl/cmd_framer.sv | 195 +++++++++++++++++++
 tb/tb_cmd_framer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_framer.sv
// Command framer: turns a uart_rx byte stream into opcode/payload commands with error reporting.
// Latency: cmd_valid rises the cycle after the last byte of a frame (or a length-0 opcode) is accepted.
// Backpressure: a finished command is held until cmd_ready; bytes that arrive while it is held are dropped as overrun.
module cmd_framer #(
  parameter int TIMEOUT_CLKS = 640,
  parameter int CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  // The counter holds the number of idle clocks already seen, so the clock
  // that would make it reach TIMEOUT_CLKS is the one that fires the timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic              rx_prev_q;
  logic [2:0]        op_q, op_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       payload_q, payload_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_pulse_q;
  logic [1:0]        err_code_q;
  logic [7:0]        err_count_q;

  logic              byte_acc;
  logic              take_opcode;
  logic              dec_vld;
  logic [2:0]        dec_len;
  logic              err_set;
  logic [1:0]        err_cause;

  // One byte per strobe: only the rising edge of rx_valid counts.
  assign byte_acc = rx_valid & ~rx_prev_q;

  // Opcode table: which byte values are commands and how many payload bytes follow.
  always_comb begin
    dec_vld = 1'b1;
    dec_len = 3'd0;
    case (rx_data)
      8'h01, 8'h02: dec_len = 3'd0;
      8'h03:        dec_len = 3'd2;
      8'h04:        dec_len = 3'd4;
      default:      dec_vld = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and frame datapath; a handshake in HOLD reuses the IDLE opcode path so a coincident byte is not lost.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    payload_d   = payload_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    take_opcode = 1'b0;
    err_set     = 1'b0;
    err_cause   = 2'd0;

    case (state_q)
      IDLE: begin
        if (byte_acc) begin
          take_opcode = 1'b1;
        end
      end
      PAYLOAD: begin
        if (byte_acc) begin
          payload_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          cnt_d = '0;
          if (({1'b0, idx_q} + 3'd1) == len_q) begin
            state_d = HOLD;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_set   = 1'b1;
          err_cause = ERR_TIMEOUT;
          state_d   = IDLE;
          payload_d = '0;
          idx_d     = '0;
          cnt_d     = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cmd_ready) begin
          state_d = IDLE;
          if (byte_acc) begin
            take_opcode = 1'b1;
          end
        end else if (byte_acc) begin
          err_set   = 1'b1;
          err_cause = ERR_OVERRUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_opcode) begin
      if (dec_vld) begin
        op_d      = rx_data[2:0];
        len_d     = dec_len;
        payload_d = '0;
        idx_d     = '0;
        cnt_d     = '0;
        state_d   = (dec_len == 3'd0) ? HOLD : PAYLOAD;
      end else begin
        err_set   = 1'b1;
        err_cause = ERR_OPCODE;
        state_d   = IDLE;
      end
    end
  end

  // Frame datapath registers and rx_valid history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q <= 1'b0;
      op_q      <= '0;
      len_q     <= '0;
      payload_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      rx_prev_q <= rx_valid;
      op_q      <= op_d;
      len_q     <= len_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  // Error strobe, sticky last cause and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= err_set;
      if (err_set) begin
        err_code_q <= err_cause;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  // Outputs: the command is presented exactly while HOLD is occupied.
  always_comb begin
    cmd_valid   = (state_q == HOLD);
    cmd_op      = op_q;
    cmd_len     = len_q;
    cmd_payload = payload_q;
    err_pulse   = err_pulse_q;
    err_code    = err_code_q;
    err_count   = err_count_q;
  end

endmodule

// File: tb/tb_cmd_framer.sv
// Bench for cmd_framer: byte strobes are scored against a stream-level model.
// Expected commands/errors are queued at send time and popped by an independent monitor.
module tb_cmd_framer;

  localparam int TO = 640;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  cmd_framer #(.TIMEOUT_CLKS(TO), .CNT_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          op;
    int          len;
    logic [31:0] pay;
    int          cyc;
  } exp_cmd_t;

  typedef struct {
    int code;
    int cnt;
    int cyc;
  } exp_err_t;

  exp_cmd_t exp_cmd[$];
  exp_err_t exp_err[$];

  // Stream-level reference: a finished command is "held" until the consumer takes it,
  // a partial frame is "collected" into a byte list.
  bit         m_held;
  bit         m_coll;
  int         m_op;
  int         m_need;
  logic [7:0] m_buf[$];
  int         m_cnt;
  int         m_last_code;

  function automatic void push_err(int code, int at);
    exp_err_t e;
    if (m_cnt < 255) m_cnt++;
    m_last_code = code;
    e.code = code;
    e.cnt  = m_cnt;
    e.cyc  = at;
    exp_err.push_back(e);
  endfunction

  function automatic void push_cmd(int at);
    exp_cmd_t c;
    c.op  = m_op;
    c.len = m_need;
    c.pay = 32'h0;
    foreach (m_buf[i]) c.pay = c.pay | (32'(m_buf[i]) << (8 * i));
    c.cyc = at;
    exp_cmd.push_back(c);
    m_held = 1'b1;
  endfunction

  // acc: cycle number of the accepting clock edge; gap: clocks until the next accepted byte.
  function automatic void model_byte(logic [7:0] b, int acc, int gap, logic rdy);
    if (m_held) begin
      if (rdy) m_held = 1'b0;
      else begin
        push_err(3, acc);
        return;
      end
    end
    if (m_coll) begin
      m_buf.push_back(b);
      if (m_buf.size() == m_need) begin
        m_coll = 1'b0;
        push_cmd(acc);
      end
    end else if (b >= 8'd1 && b <= 8'd4) begin
      m_op   = int'(b);
      m_need = (b == 8'd3) ? 2 : (b == 8'd4) ? 4 : 0;
      m_buf.delete();
      if (m_need == 0) push_cmd(acc);
      else m_coll = 1'b1;
    end else begin
      push_err(1, acc);
    end
    if (m_held && rdy) m_held = 1'b0;
    if (m_coll && gap > TO) begin
      push_err(2, acc + TO);
      m_coll = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_held = 1'b0;
    m_coll = 1'b0;
    m_buf.delete();
    m_cnt = 0;
    m_last_code = 0;
  endfunction

  // All driving tasks start and end just after a falling edge.
  task automatic send(input logic [7:0] b, input int gap);
    int w;
    w = $urandom_range(1, gap - 1);
    model_byte(b, cyc + 1, gap, cmd_ready);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (w) @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap - w) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    cmd_ready = v;
    if (v) m_held = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rgap();
    return int'($urandom_range(2, 12));
  endfunction

  // Monitor: samples after inputs settle in the low phase and scores every output event.
  bit          prev_v;
  bit          prev_hs;
  bit          stable;
  int          start_cyc;
  logic [2:0]  s_op;
  logic [2:0]  s_len;
  logic [31:0] s_pay;
  exp_cmd_t    mc;
  exp_err_t    me;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (err_pulse) begin
        if (exp_err.size() == 0) chk("err_pulse_unexpected", 32'(err_pulse), 32'd0);
        else begin
          me = exp_err.pop_front();
          chk("err_code", 32'(err_code), me.code);
          chk("err_count", 32'(err_count), me.cnt);
          chk("err_cycle", cyc, me.cyc);
        end
      end
      if (cmd_valid) begin
        if (!prev_v || prev_hs) begin
          start_cyc = cyc;
          s_op   = cmd_op;
          s_len  = cmd_len;
          s_pay  = cmd_payload;
          stable = 1'b1;
        end else if (cmd_op !== s_op || cmd_len !== s_len || cmd_payload !== s_pay) begin
          stable = 1'b0;
        end
        if (cmd_ready) begin
          if (exp_cmd.size() == 0) chk("cmd_valid_unexpected", 32'(cmd_valid), 32'd0);
          else begin
            mc = exp_cmd.pop_front();
            chk("cmd_op", 32'(cmd_op), mc.op);
            chk("cmd_len", 32'(cmd_len), mc.len);
            chk("cmd_payload", cmd_payload, mc.pay);
            chk("cmd_valid_start", start_cyc, mc.cyc);
            chk("cmd_stable", 32'(stable), 32'd1);
          end
        end
      end
      prev_v  = cmd_valid;
      prev_hs = cmd_valid && cmd_ready;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_cmd_op"}, 32'(cmd_op), 32'd0);
    chk({tag, "_cmd_len"}, 32'(cmd_len), 32'd0);
    chk({tag, "_cmd_payload"}, cmd_payload, 32'd0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int op, need, nb, kind;
    bit trunc;

    rst_n     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Two-byte payload, bytes 160 clocks apart, consumer always ready.
    send(8'h03, 160);
    send(8'hAA, 160);
    send(8'h55, 10);

    // Length-0 command held for 50 clocks before the consumer takes it.
    set_ready(1'b0);
    send(8'h02, 50);
    set_ready(1'b1);
    idle(3);

    // Two bad opcodes.
    send(8'h07, 4);
    send(8'h00, 4);

    // Timeout after a partial frame, then a fresh command.
    send(8'h04, 5);
    send(8'h11, 5);
    send(8'h22, TO + 20);
    send(8'h01, 5);

    // Gap of exactly TIMEOUT_CLKS survives; one more clock times out.
    send(8'h04, 4);
    send(8'h11, TO);
    send(8'h22, 3);
    send(8'h33, 3);
    send(8'h44, 5);
    send(8'h03, TO + 1);
    send(8'h02, 5);

    // Overrun while held, then a byte coinciding with the handshake.
    set_ready(1'b0);
    send(8'h01, 5);
    send(8'h03, 5);
    set_ready(1'b1);
    idle(3);
    set_ready(1'b0);
    send(8'h01, 5);
    set_ready(1'b1);
    send(8'h03, 3);
    send(8'hA1, 3);
    send(8'hB2, 5);

    // Random frames, with occasional bad opcodes and truncated frames.
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        b = 8'($urandom_range(5, 255));
        if ($urandom_range(0, 1) == 1) b = 8'h00;
        send(b, rgap());
      end else begin
        op    = int'($urandom_range(1, 4));
        need  = (op == 3) ? 2 : (op == 4) ? 4 : 0;
        trunc = (kind == 1) && (need > 0);
        nb    = trunc ? int'($urandom_range(0, need - 1)) : need;
        send(8'(op), (trunc && nb == 0) ? TO + 1 + int'($urandom_range(0, 8)) : rgap());
        for (int i = 0; i < nb; i++) begin
          send(8'($urandom), (trunc && i == nb - 1) ? TO + 1 + int'($urandom_range(0, 8)) : rgap());
        end
      end
    end

    // Drive the error counter past saturation.
    for (int i = 0; i < 260; i++) send(8'hFF, 2);

    // Asynchronous reset mid-frame, then a full four-byte frame.
    send(8'h04, 3);
    send(8'h11, 3);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    idle(2);
    rst_n = 1'b1;
    send(8'h04, 3);
    send(8'hDE, 3);
    send(8'hAD, 3);
    send(8'hBE, 3);
    send(8'hEF, 5);

    idle(10);
    #3;
    chk("cmd_queue_left", exp_cmd.size(), 32'd0);
    chk("err_queue_left", exp_err.size(), 32'd0);
    chk("final_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("final_err_code", 32'(err_code), m_last_code);
    chk("final_err_count", 32'(err_count), m_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
